// File: rtl/ram_r_w_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ram_r_w_fifo_ctl
// Purpose  : Single-clock FIFO controller for an external RAM with separate
//            write and read addresses. The RAM read is asynchronous, so the
//            word at ram_rd_addr is the FIFO head.
// Ports    : clk, rst_n (async, active low), clr_n (sync clear, active low)
//            push_req_n / pop_req_n  - active-low requests
//            ram_cs_n / ram_wr_n     - RAM strobes, low on an accepted push
//            ram_wr_addr / ram_rd_addr - write / read pointers
//            empty, almost_empty, half_full, almost_full, full, error
//            word_count              - occupancy 0..depth
// Revision : 1.0 - initial release
// ============================================================================
module ram_r_w_fifo_ctl #(
  parameter int depth      = 8,
  parameter int addr_width = 3,
  parameter int ae_level   = 1,
  parameter int af_level   = 1,
  parameter int err_mode   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_n,
  input  logic                  push_req_n,
  input  logic                  pop_req_n,
  output logic                  ram_cs_n,
  output logic                  ram_wr_n,
  output logic [addr_width-1:0] ram_wr_addr,
  output logic [addr_width-1:0] ram_rd_addr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  half_full,
  output logic                  almost_full,
  output logic                  full,
  output logic                  error,
  output logic [addr_width:0]   word_count
);

  localparam logic [addr_width:0]   c_depth  = (addr_width+1)'(depth);
  localparam logic [addr_width:0]   c_half   = (addr_width+1)'(depth / 2);
  localparam logic [addr_width:0]   c_ae     = (addr_width+1)'(ae_level);
  localparam logic [addr_width:0]   c_af     = (addr_width+1)'(depth - af_level);
  localparam logic [addr_width-1:0] c_last   = addr_width'(depth - 1);

  logic [addr_width-1:0] r_wr_ptr, r_rd_ptr;
  logic [addr_width:0]   r_count;
  logic                  r_empty, r_almost_empty, r_half_full, r_almost_full, r_full;
  logic                  r_error;

  logic                  w_push_ok, w_pop_ok, w_err_evt, w_error_nxt;
  logic [addr_width:0]   w_count_nxt;
  logic [addr_width-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;

  // A push while full is still accepted when a pop frees the slot in the
  // same cycle. rst_n and clr_n gate the strobe so the RAM is never written
  // while the controller is being reset or cleared.
  assign w_push_ok = rst_n & clr_n & ~push_req_n & (~r_full | ~pop_req_n);
  assign w_pop_ok  = ~pop_req_n & ~r_empty;
  assign w_err_evt = (~push_req_n & r_full & pop_req_n) | (~pop_req_n & r_empty);

  assign ram_wr_n    = ~w_push_ok;
  assign ram_cs_n    = ~w_push_ok;
  assign ram_wr_addr = r_wr_ptr;
  assign ram_rd_addr = r_rd_ptr;

  assign w_wr_ptr_nxt = (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  generate
    if (err_mode == 0) begin : g_err_sticky
      assign w_error_nxt = r_error | w_err_evt;
    end else begin : g_err_pulse
      assign w_error_nxt = w_err_evt;
    end
  endgenerate

  // Flags are computed from the next count so they line up with word_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_half_full    <= 1'b0;
      r_almost_full  <= 1'b0;
      r_full         <= 1'b0;
      r_error        <= 1'b0;
    end else if (!clr_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_half_full    <= 1'b0;
      r_almost_full  <= 1'b0;
      r_full         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop_ok)  r_rd_ptr <= w_rd_ptr_nxt;
      r_count        <= w_count_nxt;
      r_empty        <= (w_count_nxt == '0);
      r_almost_empty <= (w_count_nxt <= c_ae);
      r_half_full    <= (w_count_nxt >= c_half);
      r_almost_full  <= (w_count_nxt >= c_af);
      r_full         <= (w_count_nxt == c_depth);
      r_error        <= w_error_nxt;
    end
  end

  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign half_full    = r_half_full;
  assign almost_full  = r_almost_full;
  assign full         = r_full;
  assign error        = r_error;
  assign word_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ram_r_w_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_r_w_fifo_ctl
// Purpose  : Directed, table-driven bench for ram_r_w_fifo_ctl. Two copies of
//            the controller share stimulus: u_dut0 (sticky error) drives a
//            small RAM model, u_dut1 (pulsed error) is checked on error only.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_r_w_fifo_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_n = 1'b1;
  logic push_req_n = 1'b1;
  logic pop_req_n = 1'b1;
  logic [7:0] din = 8'h00;

  logic       cs_n0, wr_n0, e0, ae0, hf0, af0, f0, err0;
  logic [2:0] wa0, ra0;
  logic [3:0] cnt0;
  logic       cs_n1, wr_n1, e1, ae1, hf1, af1, f1, err1;
  logic [2:0] wa1, ra1;
  logic [3:0] cnt1;

  logic [7:0] mem [8];
  logic [7:0] dout;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ram_r_w_fifo_ctl #(.depth(8), .addr_width(3), .ae_level(1), .af_level(1), .err_mode(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .ram_cs_n(cs_n0), .ram_wr_n(wr_n0), .ram_wr_addr(wa0), .ram_rd_addr(ra0),
    .empty(e0), .almost_empty(ae0), .half_full(hf0), .almost_full(af0), .full(f0),
    .error(err0), .word_count(cnt0));

  ram_r_w_fifo_ctl #(.depth(8), .addr_width(3), .ae_level(1), .af_level(1), .err_mode(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .ram_cs_n(cs_n1), .ram_wr_n(wr_n1), .ram_wr_addr(wa1), .ram_rd_addr(ra1),
    .empty(e1), .almost_empty(ae1), .half_full(hf1), .almost_full(af1), .full(f1),
    .error(err1), .word_count(cnt1));

  // Synchronous-write, asynchronous-read RAM behind u_dut0.
  always @(posedge clk) begin
    if (!cs_n0 && !wr_n0) mem[wa0] <= din;
  end
  assign dout = mem[ra0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  // flags = {empty, almost_empty, half_full, almost_full, full, error}
  typedef struct {
    logic       push_n;
    logic       pop_n;
    logic       clr_n;
    logic [7:0] din;
    logic       wr_n;
    logic [2:0] wr_addr;
    logic [2:0] rd_addr;
    logic       chk_dout;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic [5:0] flags;
    logic       err1;
  } vec_t;

  vec_t vecs [22];

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    push_req_n = v.push_n;
    pop_req_n  = v.pop_n;
    clr_n      = v.clr_n;
    din        = v.din;
    #1;
    chk({tag, "_wr_n"}, {31'd0, wr_n0}, {31'd0, v.wr_n});
    chk({tag, "_cs_n"}, {31'd0, cs_n0}, {31'd0, v.wr_n});
    chk({tag, "_wr_addr"}, {29'd0, wa0}, {29'd0, v.wr_addr});
    chk({tag, "_rd_addr"}, {29'd0, ra0}, {29'd0, v.rd_addr});
    if (v.chk_dout) chk({tag, "_dout"}, {24'd0, dout}, {24'd0, v.dout});
    @(posedge clk);
    #1;
    chk({tag, "_count"}, {28'd0, cnt0}, {28'd0, v.cnt});
    chk({tag, "_flags"}, {26'd0, e0, ae0, hf0, af0, f0, err0}, {26'd0, v.flags});
    chk({tag, "_err_pulse"}, {31'd0, err1}, {31'd0, v.err1});
  endtask

  task automatic drive_idle();
    @(negedge clk);
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
    clr_n      = 1'b1;
  endtask

  initial begin
    //        push pop clr din    wr_n wa    ra    chk dout   cnt flags     err1
    vecs[0]  = '{0, 1, 1, 8'h11, 0, 3'd0, 3'd0, 0, 8'h00, 1, 6'b010000, 0};
    vecs[1]  = '{0, 1, 1, 8'h22, 0, 3'd1, 3'd0, 0, 8'h00, 2, 6'b000000, 0};
    vecs[2]  = '{0, 1, 1, 8'h33, 0, 3'd2, 3'd0, 0, 8'h00, 3, 6'b000000, 0};
    vecs[3]  = '{0, 1, 1, 8'h44, 0, 3'd3, 3'd0, 0, 8'h00, 4, 6'b001000, 0};
    vecs[4]  = '{0, 1, 1, 8'h55, 0, 3'd4, 3'd0, 0, 8'h00, 5, 6'b001000, 0};
    vecs[5]  = '{0, 1, 1, 8'h66, 0, 3'd5, 3'd0, 0, 8'h00, 6, 6'b001000, 0};
    vecs[6]  = '{0, 1, 1, 8'h77, 0, 3'd6, 3'd0, 0, 8'h00, 7, 6'b001100, 0};
    vecs[7]  = '{0, 1, 1, 8'h88, 0, 3'd7, 3'd0, 0, 8'h00, 8, 6'b001110, 0};
    // overflow: no write, pointers still, sticky vs pulsed error
    vecs[8]  = '{0, 1, 1, 8'h99, 1, 3'd0, 3'd0, 1, 8'h11, 8, 6'b001111, 1};
    vecs[9]  = '{1, 1, 1, 8'h00, 1, 3'd0, 3'd0, 1, 8'h11, 8, 6'b001111, 0};
    // drain: head visible during each pop cycle
    vecs[10] = '{1, 0, 1, 8'h00, 1, 3'd0, 3'd0, 1, 8'h11, 7, 6'b001101, 0};
    vecs[11] = '{1, 0, 1, 8'h00, 1, 3'd0, 3'd1, 1, 8'h22, 6, 6'b001001, 0};
    vecs[12] = '{1, 0, 1, 8'h00, 1, 3'd0, 3'd2, 1, 8'h33, 5, 6'b001001, 0};
    vecs[13] = '{1, 0, 1, 8'h00, 1, 3'd0, 3'd3, 1, 8'h44, 4, 6'b001001, 0};
    vecs[14] = '{1, 0, 1, 8'h00, 1, 3'd0, 3'd4, 1, 8'h55, 3, 6'b000001, 0};
    vecs[15] = '{1, 0, 1, 8'h00, 1, 3'd0, 3'd5, 1, 8'h66, 2, 6'b000001, 0};
    vecs[16] = '{1, 0, 1, 8'h00, 1, 3'd0, 3'd6, 1, 8'h77, 1, 6'b010001, 0};
    vecs[17] = '{1, 0, 1, 8'h00, 1, 3'd0, 3'd7, 1, 8'h88, 0, 6'b110001, 0};
    // push+pop while empty: push taken, pop ignored, underflow flagged
    vecs[18] = '{0, 0, 1, 8'hAA, 0, 3'd0, 3'd0, 0, 8'h00, 1, 6'b010001, 1};
    vecs[19] = '{1, 1, 1, 8'h00, 1, 3'd1, 3'd0, 1, 8'hAA, 1, 6'b010001, 0};
    // clear with a push pending: strobe suppressed, state back to reset
    vecs[20] = '{0, 1, 0, 8'hBB, 1, 3'd1, 3'd0, 0, 8'h00, 0, 6'b110000, 0};
    vecs[21] = '{1, 1, 1, 8'h00, 1, 3'd0, 3'd0, 0, 8'h00, 0, 6'b110000, 0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", {28'd0, cnt0}, 32'd0);
    chk("rst_flags", {26'd0, e0, ae0, hf0, af0, f0, err0}, 32'b110000);
    chk("rst_strobes", {30'd0, wr_n0, cs_n0}, 32'b11);
    chk("rst_addrs", {26'd0, wa0, ra0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) apply(vecs[i], i);

    // Push+pop while full: fill with B0..B7, then swap the head for C0.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      push_req_n = 1'b0;
      pop_req_n  = 1'b1;
      din        = 8'hB0 + 8'(i);
    end
    drive_idle();
    #1;
    chk("full_before_swap", {27'd0, f0, cnt0}, {27'd1, 4'd8});
    push_req_n = 1'b0;
    pop_req_n  = 1'b0;
    din        = 8'hC0;
    #1;
    chk("swap_head", {24'd0, dout}, 32'hB0);
    chk("swap_wr_n", {31'd0, wr_n0}, 32'd0);
    chk("swap_addrs", {26'd0, wa0, ra0}, 32'd0);
    @(posedge clk);
    #1;
    chk("swap_count", {28'd0, cnt0}, 32'd8);
    chk("swap_flags", {26'd0, e0, ae0, hf0, af0, f0, err0}, 32'b001110);
    chk("swap_err_pulse", {31'd0, err1}, 32'd0);
    drive_idle();
    #1;
    chk("swap_next_head", {24'd0, dout}, 32'hB1);
    chk("swap_written", {24'd0, mem[0]}, 32'hC0);
    chk("swap_rd_addr", {29'd0, ra0}, 32'd1);

    // Clear after 5 pushes: start from a clean FIFO first.
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      push_req_n = 1'b0;
      din        = 8'hD0 + 8'(i);
    end
    drive_idle();
    #1;
    chk("pre_clr_count", {28'd0, cnt0}, 32'd5);
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_count", {28'd0, cnt0}, 32'd0);
    chk("clr_flags", {26'd0, e0, ae0, hf0, af0, f0, err0}, 32'b110000);
    chk("clr_addrs", {26'd0, wa0, ra0}, 32'd0);

    // Asynchronous reset in the middle of a push.
    drive_idle();
    push_req_n = 1'b0;
    din        = 8'hE0;
    @(posedge clk);
    @(negedge clk);
    din = 8'hE1;
    #1;
    chk("mid_push_wr_n", {31'd0, wr_n0}, 32'd0);
    chk("mid_push_count", {28'd0, cnt0}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", {28'd0, cnt0}, 32'd0);
    chk("async_rst_flags", {26'd0, e0, ae0, hf0, af0, f0, err0}, 32'b110000);
    chk("async_rst_strobes", {30'd0, wr_n0, cs_n0}, 32'b11);
    chk("async_rst_addrs", {26'd0, wa0, ra0}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_r_w_fifo_ctl.md
RAM_R_W_FIFO_CTL -- requirements
Module: ram_r_w_fifo_ctl

Interface
REQ-001 The block SHALL have parameter depth, default 8: number of RAM words, legal range 2..256, power of two.
REQ-002 The block SHALL have parameter addr_width, default 3: RAM address width, equal to ceil(log2(depth)).
REQ-003 The block SHALL have parameter ae_level, default 1: almost_empty asserts when word_count <= ae_level; legal range 1..depth-1.
REQ-004 The block SHALL have parameter af_level, default 1: almost_full asserts when word_count >= depth-af_level; legal range 1..depth-1.
REQ-005 The block SHALL have parameter err_mode, default 0: 0 means error is sticky, 1 means error is a single-cycle pulse.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port clr_n, input, 1 bit: synchronous clear, active low.
REQ-009 The block SHALL have port push_req_n, input, 1 bit: write request, active low.
REQ-010 The block SHALL have port pop_req_n, input, 1 bit: read request, active low.
REQ-011 The block SHALL have port ram_cs_n, output, 1 bit: RAM chip select, active low.
REQ-012 The block SHALL have port ram_wr_n, output, 1 bit: RAM write enable, active low.
REQ-013 The block SHALL have port ram_wr_addr, output, addr_width bits: RAM write address.
REQ-014 The block SHALL have port ram_rd_addr, output, addr_width bits: RAM read address; the RAM read is asynchronous, so RAM data_out is the FIFO head.
REQ-015 The block SHALL have status outputs, 1 bit each: empty, almost_empty, half_full (word_count >= depth/2), almost_full, full.
REQ-016 The block SHALL have port error, output, 1 bit: overflow or underflow indicator.
REQ-017 The block SHALL have port word_count, output, addr_width+1 bits: current occupancy, 0..depth.

Function
REQ-018 The block SHALL keep wr_ptr and rd_ptr registers of addr_width bits each; both wrap from depth-1 to 0.
REQ-019 The block SHALL drive ram_wr_addr from wr_ptr and ram_rd_addr from rd_ptr directly, with no pipelining.
REQ-020 The block SHALL compute push_ok = !push_req_n && (!full || !pop_req_n), and drive ram_wr_n = ram_cs_n = !push_ok combinationally in the same cycle as the request.
REQ-021 The block SHALL compute pop_ok = !pop_req_n && !empty; the head word is valid on RAM data_out during the pop cycle.
REQ-022 On a push_ok edge, wr_ptr SHALL increment; on a pop_ok edge, rd_ptr SHALL increment.
REQ-023 word_count SHALL increment for push_ok only, decrement for pop_ok only, and stay unchanged when both or neither occur.
REQ-024 On a simultaneous push and pop while full, both SHALL be accepted: the write lands at wr_ptr, which equals rd_ptr, after the head was read combinationally in that cycle.
REQ-025 On a simultaneous push and pop while empty, the push SHALL be accepted, the pop SHALL be ignored, and underflow SHALL be flagged.
REQ-026 Overflow (push while full without pop) SHALL be ignored: no RAM write, no pointer change.
REQ-027 Underflow (pop while empty) SHALL be ignored, with no pointer change.
REQ-028 All flags SHALL be registered and derived from next-state word_count, so they are valid in the cycle after the edge with no extra latency.
REQ-029 When err_mode=0, error SHALL set on the edge after an overflow or underflow and hold until reset or clr_n.
REQ-030 When err_mode=1, error SHALL be high only for the cycle following each offending request.
REQ-031 clr_n=0 at an edge SHALL force the reset state regardless of requests, and ram_wr_n/ram_cs_n SHALL be held high while clr_n=0.

Reset
REQ-032 While rst_n=0: wr_ptr=0, rd_ptr=0, word_count=0, empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0, ram_wr_n=1, ram_cs_n=1.
REQ-033 Assertion of rst_n SHALL take effect immediately, independent of clk, aborting any in-flight request; release SHALL be synchronous to clk by the integrator.

Verification
REQ-034 The bench SHALL cover: reset, then 8 pushes of 0x11..0x88 (defaults) -> word_count steps 1..8; almost_full at count 7; full at 8; ram_wr_addr 0..7.
REQ-035 The bench SHALL cover: 9th push while full -> ram_wr_n stays 1, count=8, error=1 and sticky in err_mode=0.
REQ-036 The bench SHALL cover: 8 pops after fill -> RAM data_out 0x11..0x88 in order; empty=1 after the 8th; rd_ptr wraps to 0.
REQ-037 The bench SHALL cover: simultaneous push/pop while full, and again while empty -> full case count stays 8; empty case count becomes 1 and error pulses for one cycle in err_mode=1.
REQ-038 The bench SHALL cover: 5 pushes then clr_n low one cycle -> count=0, empty=1, error=0; then rst_n asserted mid-push -> outputs reach reset values without a clock edge.
